// File: rtl/whack_pkg.sv
// Shared definitions for the UART command decoder.
//   - ASCII command and response codes exchanged with the PC
//   - Parser state encoding
//   - bcd_to_ascii: converts one BCD digit to its ASCII character
package whack_pkg;

  localparam logic [7:0] CMD_START    = 8'h53;  // 'S'
  localparam logic [7:0] CMD_HIT      = 8'h48;  // 'H'
  localparam logic [7:0] CMD_WHACK    = 8'h57;  // 'W'
  localparam logic [7:0] CMD_QUERY    = 8'h51;  // 'Q'
  localparam logic [7:0] RSP_BUSY     = 8'h42;  // 'B'
  localparam logic [7:0] RSP_INACTIVE = 8'h58;  // 'X'
  localparam logic [7:0] RSP_ERR      = 8'h3F;  // '?'
  localparam logic [7:0] CR           = 8'h0D;
  localparam logic [7:0] LF           = 8'h0A;
  localparam logic [7:0] ASCII_ZERO   = 8'h30;  // '0'

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_WAIT_ARG = 1'b1
  } parser_state_t;

  function automatic logic [7:0] bcd_to_ascii(input logic [3:0] digit);
    return ASCII_ZERO + {4'h0, digit};
  endfunction

endpackage

// File: rtl/uart_cmd_decoder_if.sv
// Signal bundle between the decoder and its neighbours
// (uart_rx, uart_tx, game FSM, score counter).
//   slave  : the decoder's view (consumes rx bytes and status, drives pulses and tx)
//   master : the environment's view (drives rx bytes and status, observes outputs)
interface uart_cmd_decoder_if #(
  parameter int NUM_MOLES = 5
) ();
  logic [7:0]           rx_data;
  logic                 rx_ready;
  logic                 tx_busy;
  logic                 game_active;
  logic [7:0]           score_bcd;
  logic                 start_pulse;
  logic                 hit_pulse;
  logic [NUM_MOLES-1:0] whack_onehot;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 overflow;

  modport slave (
    input  rx_data, rx_ready, tx_busy, game_active, score_bcd,
    output start_pulse, hit_pulse, whack_onehot, tx_start, tx_data, overflow
  );

  modport master (
    output rx_data, rx_ready, tx_busy, game_active, score_bcd,
    input  start_pulse, hit_pulse, whack_onehot, tx_start, tx_data, overflow
  );
endinterface

// File: rtl/resp_fifo.sv
// Synchronous response FIFO.
// Ports:
//   clock, reset : clock and asynchronous active-high reset
//   push         : number of bytes written this cycle (0, 1 or 2)
//   push_data    : push_data[0] is written first, push_data[1] second
//   pop          : drop the head entry
//   head         : oldest entry (valid when count != 0)
//   count        : current occupancy, 0..DEPTH
// The caller must never push more than the free space or pop when empty;
// a simultaneous push and pop is allowed.
module resp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [1:0]                  push,
  input  logic [1:0][WIDTH-1:0]       push_data,
  input  logic                        pop,
  output logic [WIDTH-1:0]            head,
  output logic [$clog2(DEPTH):0]      count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [AW-1:0]    w_wr_ptr_p1;

  // DEPTH is a power of two, so pointer arithmetic wraps naturally.
  assign w_wr_ptr_p1 = r_wr_ptr + AW'(1);

  // Storage is not reset: only the pointers define which entries are live.
  always_ff @(posedge clock) begin
    if (push != 2'd0) r_mem[r_wr_ptr] <= push_data[0];
    if (push == 2'd2) r_mem[w_wr_ptr_p1] <= push_data[1];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(push);
      r_rd_ptr <= r_rd_ptr + AW'(pop);
      r_count  <= r_count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule

// File: rtl/uart_cmd_decoder.sv
// PC-to-FPGA command decoder.
// Parses bytes from uart_rx into one-cycle game control pulses and queues
// ASCII responses for uart_tx through resp_fifo.
// Ports:
//   clock : system clock
//   reset : asynchronous active-high reset
//   bus   : uart_cmd_decoder_if.slave
//           in : rx_data, rx_ready, tx_busy, game_active, score_bcd
//           out: start_pulse, hit_pulse, whack_onehot, tx_start, tx_data, overflow
module uart_cmd_decoder
  import whack_pkg::*;
#(
  parameter int TIMEOUT_CLKS = 1_000_000,
  parameter int FIFO_DEPTH   = 4,
  parameter int NUM_MOLES    = 5
) (
  input  logic               clock,
  input  logic               reset,
  uart_cmd_decoder_if.slave  bus
);
  localparam int               CNT_W    = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CLKS - 1);
  localparam int               AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]      DEPTH_C  = (AW+1)'(FIFO_DEPTH);

  parser_state_t          r_state, w_state_next;
  logic [CNT_W-1:0]       r_tmo_cnt, w_tmo_cnt_next;
  logic                   r_start_pulse, w_start_next;
  logic                   r_hit_pulse, w_hit_next;
  logic [NUM_MOLES-1:0]   r_whack, w_whack_next;
  logic                   r_tx_start;
  logic [7:0]             r_tx_data;
  logic                   r_overflow;

  logic [1:0]             w_rsp_n;      // response bytes requested this cycle
  logic [1:0][7:0]        w_rsp_data;
  logic [1:0]             w_push;
  logic                   w_pop;
  logic                   w_fits;
  logic [7:0]             w_head;
  logic [AW:0]            w_count;
  logic [AW:0]            w_free;
  logic                   w_is_digit;
  logic [7:0]             w_arg_idx;

  assign w_arg_idx  = bus.rx_data - ASCII_ZERO;
  assign w_is_digit = (bus.rx_data >= ASCII_ZERO) &&
                      (bus.rx_data < (ASCII_ZERO + 8'(NUM_MOLES)));

  // Parser next-state and requested actions.
  always_comb begin
    w_state_next   = r_state;
    w_tmo_cnt_next = r_tmo_cnt;
    w_start_next   = 1'b0;
    w_hit_next     = 1'b0;
    w_whack_next   = '0;
    w_rsp_n        = 2'd0;
    w_rsp_data[0]  = RSP_ERR;
    w_rsp_data[1]  = RSP_ERR;

    case (r_state)
      ST_IDLE: begin
        if (bus.rx_ready) begin
          case (bus.rx_data)
            CMD_START: begin
              if (!bus.game_active) begin
                w_start_next = 1'b1;
              end else begin
                w_rsp_n       = 2'd1;
                w_rsp_data[0] = RSP_BUSY;
              end
            end
            CMD_HIT: begin
              if (bus.game_active) begin
                w_hit_next = 1'b1;
              end else begin
                w_rsp_n       = 2'd1;
                w_rsp_data[0] = RSP_INACTIVE;
              end
            end
            CMD_WHACK: begin
              w_state_next   = ST_WAIT_ARG;
              w_tmo_cnt_next = '0;
            end
            CMD_QUERY: begin
              w_rsp_n       = 2'd2;
              w_rsp_data[0] = bcd_to_ascii(bus.score_bcd[7:4]);
              w_rsp_data[1] = bcd_to_ascii(bus.score_bcd[3:0]);
            end
            CR, LF: begin
            end
            default: w_rsp_n = 2'd1;
          endcase
        end
      end

      ST_WAIT_ARG: begin
        if (bus.rx_ready) begin
          // The argument byte is always consumed here, never re-parsed.
          w_state_next = ST_IDLE;
          if (w_is_digit && bus.game_active) begin
            w_whack_next = NUM_MOLES'(1) << w_arg_idx;
          end else if (w_is_digit) begin
            w_rsp_n       = 2'd1;
            w_rsp_data[0] = RSP_INACTIVE;
          end else begin
            w_rsp_n = 2'd1;
          end
        end else if (r_tmo_cnt == TMO_LAST) begin
          w_state_next = ST_IDLE;
          w_rsp_n      = 2'd1;
        end else begin
          w_tmo_cnt_next = r_tmo_cnt + CNT_W'(1);
        end
      end

      default: w_state_next = ST_IDLE;
    endcase
  end

  // Admission uses occupancy before any same-cycle pop, so a query needs
  // two genuinely free slots and is written all-or-nothing.
  assign w_free = DEPTH_C - w_count;
  assign w_fits = ((AW+1)'(w_rsp_n) <= w_free);
  assign w_push = w_fits ? w_rsp_n : 2'd0;

  // The r_tx_start term covers the cycle before uart_tx raises tx_busy.
  assign w_pop = (w_count != '0) && !bus.tx_busy && !r_tx_start;

  resp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_resp_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (w_push),
    .push_data (w_rsp_data),
    .pop       (w_pop),
    .head      (w_head),
    .count     (w_count)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_tmo_cnt     <= '0;
      r_start_pulse <= 1'b0;
      r_hit_pulse   <= 1'b0;
      r_whack       <= '0;
      r_tx_start    <= 1'b0;
      r_tx_data     <= 8'h00;
      r_overflow    <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_tmo_cnt     <= w_tmo_cnt_next;
      r_start_pulse <= w_start_next;
      r_hit_pulse   <= w_hit_next;
      r_whack       <= w_whack_next;
      r_tx_start    <= w_pop;
      if (w_pop) r_tx_data <= w_head;
      if ((w_rsp_n != 2'd0) && !w_fits) r_overflow <= 1'b1;
    end
  end

  assign bus.start_pulse  = r_start_pulse;
  assign bus.hit_pulse    = r_hit_pulse;
  assign bus.whack_onehot = r_whack;
  assign bus.tx_start     = r_tx_start;
  assign bus.tx_data      = r_tx_data;
  assign bus.overflow     = r_overflow;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench for uart_cmd_decoder: stimulus pushes hand-computed
// expected pulses / tx bytes; a forked monitor pops and compares them
// whenever the DUT presents a pulse or tx_start.
module tb_uart_cmd_decoder;
  import whack_pkg::*;

  localparam int NM       = 5;
  localparam int TMO      = 100;
  localparam int BUSY_CYC = 6;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  uart_cmd_decoder_if #(.NUM_MOLES(NM)) bus ();

  uart_cmd_decoder #(
    .TIMEOUT_CLKS (TMO),
    .FIFO_DEPTH   (4),
    .NUM_MOLES    (NM)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic          start;
    logic          hit;
    logic [NM-1:0] whack;
    int            cyc;
  } pulse_t;

  typedef struct {
    logic [7:0] data;
    int         cyc;   // -1: timing not checked
  } txe_t;

  pulse_t exp_pulse[$];
  txe_t   exp_tx[$];
  int     cyc = 0;
  int     n_chk = 0;
  int     n_pass = 0;
  logic   hold_busy = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  // uart_tx model: busy from the cycle after tx_start for BUSY_CYC cycles.
  initial begin
    int   busy_cnt;
    logic pend;
    busy_cnt    = 0;
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clock);
      pend = bus.tx_start;
      @(posedge clock);
      #1;
      if (pend) busy_cnt = BUSY_CYC;
      else if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
      bus.tx_busy = hold_busy || (busy_cnt != 0);
    end
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk = n_chk + 1;
    if (act === req) n_pass = n_pass + 1;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
  endfunction

  task automatic send(input logic [7:0] b, input logic act, input logic [7:0] score,
                      input logic e_start, input logic e_hit, input logic [NM-1:0] e_whack,
                      input int n_rsp, input logic [7:0] r0, input logic [7:0] r1,
                      input bit exact);
    pulse_t p;
    txe_t   t;
    @(negedge clock);
    bus.rx_data     = b;
    bus.rx_ready    = 1'b1;
    bus.game_active = act;
    bus.score_bcd   = score;
    $display("rx 0x%02h active=%0d score=%02h", b, act, score);
    if (e_start || e_hit || (e_whack != '0)) begin
      p.start = e_start; p.hit = e_hit; p.whack = e_whack; p.cyc = cyc + 1;
      exp_pulse.push_back(p);
    end
    if (n_rsp >= 1) begin
      t.data = r0; t.cyc = exact ? cyc + 2 : -1;
      exp_tx.push_back(t);
    end
    if (n_rsp == 2) begin
      t.data = r1; t.cyc = -1;
      exp_tx.push_back(t);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      bus.rx_ready = 1'b0;
    end
  endtask

  task automatic drain(input int limit);
    int i;
    i = 0;
    idle(1);
    while (((exp_tx.size() != 0) || (exp_pulse.size() != 0)) && (i < limit)) begin
      idle(1);
      i = i + 1;
    end
    chk("drain_outstanding", exp_tx.size() + exp_pulse.size(), 0);
    idle(BUSY_CYC + 4);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_start"},    bus.start_pulse, 0);
    chk({tag, "_hit"},      bus.hit_pulse, 0);
    chk({tag, "_whack"},    bus.whack_onehot, 0);
    chk({tag, "_tx_start"}, bus.tx_start, 0);
    chk({tag, "_tx_data"},  bus.tx_data, 0);
    chk({tag, "_overflow"}, bus.overflow, 0);
  endtask

  initial begin
    txe_t te;
    bus.rx_data     = 8'h00;
    bus.rx_ready    = 1'b0;
    bus.game_active = 1'b0;
    bus.score_bcd   = 8'h00;

    fork
      begin : monitor
        pulse_t pe;
        txe_t   me;
        logic   busy_prev;
        busy_prev = 1'b0;
        forever begin
          @(negedge clock);
          if (!reset) begin
            if (bus.start_pulse || bus.hit_pulse || (bus.whack_onehot != '0)) begin
              $display("pulse start=%0d hit=%0d whack=%b cycle %0d",
                       bus.start_pulse, bus.hit_pulse, bus.whack_onehot, cyc);
              if (exp_pulse.size() == 0) begin
                chk("unexpected_pulse", {bus.start_pulse, bus.hit_pulse, bus.whack_onehot}, 0);
              end else begin
                pe = exp_pulse.pop_front();
                chk("pulse_vec", {bus.start_pulse, bus.hit_pulse, bus.whack_onehot},
                    {pe.start, pe.hit, pe.whack});
                chk("pulse_cyc", cyc, pe.cyc);
              end
            end
            if (bus.tx_start) begin
              $display("tx 0x%02h cycle %0d", bus.tx_data, cyc);
              chk("tx_start_while_busy", busy_prev, 0);
              if (exp_tx.size() == 0) begin
                chk("unexpected_tx", {1'b1, bus.tx_data}, 0);
              end else begin
                me = exp_tx.pop_front();
                chk("tx_data", bus.tx_data, me.data);
                if (me.cyc >= 0) chk("tx_cyc", cyc, me.cyc);
              end
            end
          end
          busy_prev = bus.tx_busy;
        end
      end
    join_none

    // Reset state
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    @(negedge clock);
    reset = 1'b0;
    idle(2);

    // Start / hit with both game states; CR/LF ignored
    send(CMD_START, 1'b0, 8'h00, 1, 0, '0, 0, 8'h00, 8'h00, 0);
    idle(4);
    send(CMD_HIT, 1'b0, 8'h00, 0, 0, '0, 1, RSP_INACTIVE, 8'h00, 1);
    drain(50);
    send(CMD_START, 1'b1, 8'h00, 0, 0, '0, 1, RSP_BUSY, 8'h00, 1);
    drain(50);
    send(CMD_HIT, 1'b1, 8'h00, 0, 1, '0, 0, 8'h00, 8'h00, 0);
    send(CR, 1'b1, 8'h00, 0, 0, '0, 0, 8'h00, 8'h00, 0);
    send(LF, 1'b1, 8'h00, 0, 0, '0, 0, 8'h00, 8'h00, 0);
    drain(50);

    // Score query: two bytes, second only after busy falls
    send(CMD_QUERY, 1'b1, 8'h27, 0, 0, '0, 2, 8'h32, 8'h37, 1);
    idle(1);
    bus.score_bcd = 8'h99;
    drain(100);

    // Whack argument handling
    send(CMD_WHACK, 1'b1, 8'h00, 0, 0, '0, 0, 8'h00, 8'h00, 0);
    send(8'h33, 1'b1, 8'h00, 0, 0, 5'b01000, 0, 8'h00, 8'h00, 0);
    idle(1);
    send(CMD_WHACK, 1'b1, 8'h00, 0, 0, '0, 0, 8'h00, 8'h00, 0);
    send(8'h37, 1'b1, 8'h00, 0, 0, '0, 1, RSP_ERR, 8'h00, 1);
    drain(50);
    send(CMD_WHACK, 1'b1, 8'h00, 0, 0, '0, 0, 8'h00, 8'h00, 0);
    send(8'h34, 1'b1, 8'h00, 0, 0, 5'b10000, 0, 8'h00, 8'h00, 0);
    send(CMD_WHACK, 1'b1, 8'h00, 0, 0, '0, 0, 8'h00, 8'h00, 0);
    send(8'h35, 1'b1, 8'h00, 0, 0, '0, 1, RSP_ERR, 8'h00, 1);
    send(CMD_WHACK, 1'b0, 8'h00, 0, 0, '0, 0, 8'h00, 8'h00, 0);
    send(8'h32, 1'b0, 8'h00, 0, 0, '0, 1, RSP_INACTIVE, 8'h00, 0);
    drain(100);

    // Argument timeout: '?' enqueued TMO clocks after 'W', sent one later
    send(CMD_WHACK, 1'b1, 8'h00, 0, 0, '0, 0, 8'h00, 8'h00, 0);
    te.data = RSP_ERR;
    te.cyc  = cyc + TMO + 2;
    exp_tx.push_back(te);
    drain(TMO + 50);
    send(CMD_START, 1'b0, 8'h00, 1, 0, '0, 0, 8'h00, 8'h00, 0);
    drain(50);

    // Single-byte overflow: five '?' into a 4-deep FIFO while TX is held
    hold_busy = 1'b1;
    idle(3);
    for (int i = 0; i < 5; i++)
      send(8'h5A, 1'b1, 8'h00, 0, 0, '0, (i < 4) ? 1 : 0, RSP_ERR, 8'h00, 0);
    idle(2);
    chk("overflow_set", bus.overflow, 1);
    hold_busy = 1'b0;
    drain(200);
    chk("overflow_sticky", bus.overflow, 1);

    // Reset while in WAIT_ARG with three queued bytes
    hold_busy = 1'b1;
    idle(3);
    for (int i = 0; i < 3; i++)
      send(8'h5A, 1'b1, 8'h00, 0, 0, '0, 1, RSP_ERR, 8'h00, 0);
    send(CMD_WHACK, 1'b1, 8'h00, 0, 0, '0, 0, 8'h00, 8'h00, 0);
    idle(2);
    @(negedge clock);
    reset = 1'b1;
    exp_tx.delete();
    hold_busy = 1'b0;
    idle(2);
    check_all_zero("midrst");
    @(negedge clock);
    reset = 1'b0;
    idle(15);
    send(8'h32, 1'b1, 8'h00, 0, 0, '0, 1, RSP_ERR, 8'h00, 1);
    drain(50);

    // Query needs two free slots: dropped with one free
    hold_busy = 1'b1;
    idle(3);
    for (int i = 0; i < 3; i++)
      send(8'h5A, 1'b1, 8'h00, 0, 0, '0, 1, RSP_ERR, 8'h00, 0);
    send(CMD_QUERY, 1'b1, 8'h27, 0, 0, '0, 0, 8'h00, 8'h00, 0);
    idle(2);
    chk("q_atomic_overflow", bus.overflow, 1);
    hold_busy = 1'b0;
    drain(200);

    // Query accepted with exactly two free slots
    hold_busy = 1'b1;
    idle(3);
    send(8'h5A, 1'b1, 8'h00, 0, 0, '0, 1, RSP_ERR, 8'h00, 0);
    send(8'h5A, 1'b1, 8'h00, 0, 0, '0, 1, RSP_ERR, 8'h00, 0);
    send(CMD_QUERY, 1'b1, 8'h41, 0, 0, '0, 2, 8'h34, 8'h31, 0);
    idle(2);
    hold_busy = 1'b0;
    drain(200);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
PC-to-FPGA command decoder. It parses the byte stream from the UART receiver into one-cycle game control pulses, and queues ASCII response bytes back to the UART transmitter through a small FIFO. It sits between the uart_rx/uart_tx instances and the game FSM / score counter, and replaces the ad-hoc single-byte compares in the top level.

Parameters:
TIMEOUT_CLKS, 1_000_000, clocks allowed between 'W' and its argument byte (10 ms at 100 MHz).
FIFO_DEPTH, 4, response FIFO entries; power of 2, minimum 2.
NUM_MOLES, 5, number of mole positions; width of whack_onehot.

Ports:
clock  in  1  system clock, 100 MHz.
reset  in  1  asynchronous, active-high reset.
rx_data  in  8  byte from uart_rx; valid when rx_ready=1.
rx_ready  in  1  one-cycle strobe, new byte available.
tx_busy  in  1  uart_tx busy; high the cycle after tx_start, until the stop bit ends.
game_active  in  1  game FSM running flag.
score_bcd  in  8  {tens, ones} BCD score.
start_pulse  out  1  one-cycle game start request.
hit_pulse  out  1  one-cycle generic hit credit.
whack_onehot  out  NUM_MOLES  one-cycle one-hot mole whack.
tx_start  out  1  one-cycle transmit request.
tx_data  out  8  byte to transmit; held stable while tx_busy=1.
overflow  out  1  sticky flag; a response was dropped because the FIFO was full.

Behaviour:
- Reset: all outputs 0, parser state IDLE, FIFO empty, timeout counter 0.
- Parser states: IDLE and WAIT_ARG. All pulse outputs are registered and appear 1 cycle after the rx_ready cycle.
- IDLE, one action per byte:
  - 'S': if !game_active, start_pulse; else enqueue 'B'.
  - 'H': if game_active, hit_pulse, no response; else enqueue 'X'.
  - 'W': go to WAIT_ARG and clear the timeout counter.
  - 'Q': enqueue tens+'0' then ones+'0'. score_bcd is sampled in the rx_ready cycle.
  - 0x0D or 0x0A: ignored.
  - Any other byte: enqueue '?'.
- WAIT_ARG:
  - Byte '0'..'0'+NUM_MOLES-1 with game_active: whack_onehot = 1 << (byte-'0'), then IDLE.
  - Valid digit with !game_active: enqueue 'X', then IDLE.
  - Any other byte: enqueue '?', then IDLE. The byte is consumed and not re-parsed.
  - Counter reaches TIMEOUT_CLKS-1 with no byte: enqueue '?', then IDLE.
- Response FIFO:
  - 'Q' enqueues atomically: if fewer than 2 entries are free, both bytes are dropped and overflow is set.
  - A single-byte enqueue into a full FIFO is dropped and sets overflow.
  - overflow clears only on reset.
  - Push and pop in the same cycle are both allowed; occupancy is then unchanged.
- TX handshake:
  - Pop when FIFO non-empty, tx_busy=0, and tx_start was 0 last cycle. This guard covers the busy-assertion latency.
  - On pop: tx_start=1 for one cycle and tx_data=head. tx_data holds until the next pop.
  - Worst case from enqueue into an empty FIFO with idle TX to tx_start is 1 cycle.
- Reset mid-operation aborts the parser, flushes the FIFO, and forces tx_start low. A byte already in flight inside uart_tx is that block's concern.
- Only one rx byte is processed per rx_ready; back-to-back rx_ready on consecutive cycles must each be handled.

Decomposition:
- Shared package (whack_pkg):
  - ASCII constants: CMD_START 'S', CMD_HIT 'H', CMD_WHACK 'W', CMD_QUERY 'Q', RSP_BUSY 'B', RSP_INACTIVE 'X', RSP_ERR '?', CR, LF.
  - Parser state encoding.
- One sub-module: resp_fifo, a synchronous FIFO with parameters DEPTH and WIDTH=8.
  - Ports: push, push_data, pop, head, count.
  - count is used for the 2-free atomic check.

Test Plan:
1. game_active=0; rx 'S' → start_pulse=1 for exactly 1 cycle, 1 cycle after rx_ready; no tx_start.
2. game_active=1, score_bcd=8'h27; rx 'Q' → tx_start twice, with tx_data 0x32 ('2') then 0x37 ('7'). The second start occurs only after tx_busy falls.
3. game_active=1; rx 'W' then '3' → whack_onehot=5'b01000 for 1 cycle. Then rx 'W' then '7' → no whack, tx '?'.
4. TIMEOUT_CLKS=100; rx 'W' with no further bytes → tx '?' at cycle 100. A subsequent 'S' with game_active=0 yields start_pulse.
5. Hold tx_busy=1; send 'Z' five times → 4 × '?' queued, overflow=1. Release tx_busy → exactly 4 '?' bytes transmitted.
6. Assert reset while in WAIT_ARG with 3 queued bytes → all outputs 0 and FIFO empty. After release, rx '2' → '?' (parsed in IDLE, not as an argument).
